// File: rtl/trace_packer_if.sv
// trace_packer_if: trace beat input, config bus and packed-vector output of trace_packer
interface trace_packer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);
  logic                         tracing;
  logic [7:0]                   configId;
  logic [7:0]                   configData;
  logic                         valid_in;
  logic [DATA_WIDTH-1:0]        data_in;
  logic [1:0]                   eof_in;
  logic                         ready_out;
  logic                         full_in;
  logic                         enqueue;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [1:0]                   eof_out;
  logic [$clog2(N):0]           lane_count_out;
  modport master (
    output tracing, configId, configData, valid_in, data_in, eof_in, full_in,
    input  ready_out, enqueue, vector_out, eof_out, lane_count_out
  );
  modport slave (
    input  tracing, configId, configData, valid_in, data_in, eof_in, full_in,
    output ready_out, enqueue, vector_out, eof_out, lane_count_out
  );
endinterface

// File: rtl/trace_packer.sv
// trace_packer: packs up to K scalar trace beats into an N-lane vector, closed early on eof
module trace_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int INITIAL_PACK       = 0
) (
  input logic          clk,
  input logic          rst_n,
  trace_packer_if.slave bus
);
  localparam int LCW = $clog2(N) + 1;
  localparam int PW  = LCW - 1;
  localparam logic [LCW-1:0] K_INIT = LCW'((INITIAL_PACK <= 0 || INITIAL_PACK > N) ? N : INITIAL_PACK);
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  logic [LCW-1:0] k;
  logic [LCW-1:0] cfg_k;
  logic [PW-1:0]  ptr;
  vec_t           fill;
  vec_t           out_vec;
  vec_t           nxt_vec;
  logic [1:0]     out_eof;
  logic [LCW-1:0] out_cnt;
  logic           out_valid;
  logic           enq;
  logic           ready;
  logic           accept;
  logic           close;
  logic           cfg;
  // Lanes above ptr are always zero in fill, so the closing vector needs no masking.
  always_comb begin
    enq     = rst_n & out_valid & ~bus.full_in & bus.tracing;
    ready   = rst_n & bus.tracing & (~out_valid | enq);
    accept  = bus.valid_in & ready;
    close   = accept & (({1'b0, ptr} == k - LCW'(1)) | (bus.eof_in != 2'b00));
    cfg     = ~bus.tracing & (bus.configId == 8'(PERSONAL_CONFIG_ID));
    cfg_k   = (bus.configData == 8'd0 || 32'(bus.configData) > N) ? LCW'(N) : LCW'(bus.configData);
    nxt_vec = fill;
    nxt_vec[ptr] = bus.data_in;
  end
  assign bus.enqueue        = enq;
  assign bus.ready_out      = ready;
  assign bus.vector_out     = out_valid ? out_vec : '0;
  assign bus.eof_out        = out_valid ? out_eof : 2'b00;
  assign bus.lane_count_out = out_valid ? out_cnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= K_INIT;
      ptr  <= '0;
      fill <= '0;
    end else if (cfg) begin
      k    <= cfg_k;
      ptr  <= '0;
      fill <= '0;
    end else if (close) begin
      ptr  <= '0;
      fill <= '0;
    end else if (accept) begin
      ptr       <= ptr + PW'(1);
      fill[ptr] <= bus.data_in;
    end
  end
  // A close in the same cycle as an enqueue reloads the output register back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec   <= '0;
      out_eof   <= 2'b00;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (close) begin
      out_vec   <= nxt_vec;
      out_eof   <= bus.eof_in;
      out_cnt   <= {1'b0, ptr} + LCW'(1);
      out_valid <= 1'b1;
    end else if (enq) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/trace_packer.md
TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 Parameter N, default 8, lanes per output vector.
REQ-002 Parameter DATA_WIDTH, default 32, bits per lane.
REQ-003 Parameter PERSONAL_CONFIG_ID, default 0, config address this block responds to.
REQ-004 Parameter INITIAL_PACK, default 0, reset value of pack count K (0 = N).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tracing  input  1  1 = trace mode, 0 = reconfiguration mode.
REQ-008 configId  input  8  config bus address.
REQ-009 configData  input  8  config bus data.
REQ-010 valid_in  input  1  upstream scalar beat valid.
REQ-011 data_in  input  DATA_WIDTH  upstream scalar.
REQ-012 eof_in  input  2  end-of-frame flags on this beat (bit0, bit1 independent levels).
REQ-013 ready_out  output  1  block accepts beat this cycle.
REQ-014 full_in  input  1  downstream input-buffer full.
REQ-015 enqueue  output  1  vector_out/eof_out written downstream this cycle.
REQ-016 vector_out  output  DATA_WIDTH x N  packed vector, lane 0 = first accepted scalar.
REQ-017 eof_out  output  2  eof flags of packed vector.
REQ-018 lane_count_out  output  clog2(N)+1  number of valid lanes in vector_out (1..N).

Function
REQ-019 Beat accepted iff valid_in & ready_out.
REQ-020 Accepted data_in written into fill-register lane ptr; ptr increments by 1.
REQ-021 Beat closes vector when ptr==K-1 or eof_in!=2'b00.
REQ-022 On close: fill lanes 0..ptr (incl. current beat) move to output register, lanes ptr+1..N-1 zero, eof_out<=eof_in, lane_count_out<=ptr+1, out_valid<=1, ptr<=0, fill register cleared.
REQ-023 Latency: closing beat at cycle t -> enqueue high at t+1 earliest.
REQ-024 enqueue = out_valid & ~full_in & tracing (combinational from registers and full_in).
REQ-025 ready_out = tracing & (~out_valid | enqueue); non-closing beats also gated by this rule.
REQ-026 On enqueue without close in same cycle: out_valid<=0 next cycle.
REQ-027 Enqueue and close in same cycle: output register reloaded with new vector, out_valid stays 1; sustained throughput one beat/cycle.
REQ-028 While full_in=1 and out_valid=1: output register, eof_out, lane_count_out held stable; ready_out=0.
REQ-029 vector_out, eof_out, lane_count_out zero whenever out_valid=0.
REQ-030 tracing=0: ready_out=0, enqueue=0; fill register, ptr, output register retained.
REQ-031 tracing=0 & configId==PERSONAL_CONFIG_ID: K<=configData, with configData==0 or >N mapped to N; ptr<=0, fill register discarded; pending output register retained.
REQ-032 K=1: every beat closes; eof_in on a beat that would close anyway yields single closed vector, never an extra empty one.
REQ-033 No vector with lane_count 0 ever enqueued.

Reset
REQ-034 rst_n low asynchronously clears ptr, fill register, output register, out_valid, eof_out, lane_count_out; ready_out and enqueue low while rst_n low.
REQ-035 K reset value = INITIAL_PACK mapped per REQ-031.
REQ-036 Reset mid-vector discards partial fill and any pending output; first beat after release lands in lane 0.

Verification
REQ-037 N=8, K=8, tracing=1, full_in=0, 8 back-to-back beats 1..8 -> one enqueue cycle after beat 8, vector_out={1..8}, lane_count 8, eof_out 00.
REQ-038 Beats 1,2,3 with eof_in=01 on 3 -> enqueue, lanes {1,2,3,0,0,0,0,0}, lane_count 3, eof_out 01.
REQ-039 Close with full_in=1 for 4 cycles -> enqueue 0, ready_out 0, outputs stable; full_in drops -> single enqueue same cycle.
REQ-040 tracing=0, configId=PERSONAL_CONFIG_ID, configData=2, then 4 beats 10,20,30,40 -> two enqueues, {10,20} then {30,40}, lane_count 2; configData=0 -> K=8.
REQ-041 16 continuous beats, K=8 -> enqueue at beat 8+1 and 16+1, ready_out never drops.
REQ-042 rst_n low after 5 beats, release, 8 beats 100..107 -> vector_out={100..107}, no stale lanes.
